l1c_mem_responder: RTL and testbench

- Memory-side responder for the L1 data cache's D-side request interface (D_req/D_addr/D_write/D_in/D_type -> D_out/D_wait).
- Serves cacheable read misses as 4-beat line bursts, uncacheable reads as single beats, and all writes as single byte-strobed beats.
- Backed by an internal word array.
- Sits between the L1 data cache and the bus/DRAM wrapper; also serves as the bench's memory model for the cache.

---
 rtl/l1c_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_l1c_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1c_mem_responder.sv
// Memory-side responder for the L1 data cache request port: 4-beat line bursts
// for cacheable reads, single beats for uncacheable reads and byte-strobed writes.
`timescale 1ns/1ps

`ifndef CACHE_BYTE
`define CACHE_BYTE  3'b000
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD 3'b001
`endif
`ifndef CACHE_WORD
`define CACHE_WORD  3'b010
`endif

module l1c_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 1,
  parameter logic [21:0] UNCACHE_TAG = 22'h040000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        D_wait
);

  // Handshake: D_req is held high by the requester until its final beat. A beat
  // is delivered (read) or accepted (write) in every cycle where D_wait = 0.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LAT   = 2'd1;
  localparam logic [1:0] S_BEAT  = 2'd2;
  localparam logic [1:0] S_RECOV = 2'd3;

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned LAT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [LAT_W-1:0] RD_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_INIT = LAT_W'(WR_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        boff_q, boff_d;
  logic              write_q, write_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        type_q, type_d;
  logic              cache_q, cache_d;
  logic              wait_q, wait_d;
  logic [31:0]       out_q, out_d;

  logic [31:0]       mem_q [2**ADDR_W];
  logic              mem_we;
  logic [3:0]        strb;
  logic              last_beat;
  logic [LAT_W-1:0]  lat_init;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    widx_d    = widx_q;
    boff_d    = boff_q;
    write_d   = write_q;
    data_d    = data_q;
    type_d    = type_q;
    cache_d   = cache_q;
    mem_we    = 1'b0;
    lat_init  = '0;
    last_beat = write_q | ~cache_q | (beat_q == 2'd3);

    case (state_q)
      S_IDLE: begin
        if (D_req) begin
          widx_d   = D_addr[ADDR_W+1:2];
          boff_d   = D_addr[1:0];
          write_d  = D_write;
          data_d   = D_in;
          type_d   = D_type;
          cache_d  = (D_addr[31:10] != UNCACHE_TAG);
          lat_init = D_write ? WR_INIT : RD_INIT;
          lat_d    = lat_init;
          beat_d   = 2'd0;
          // A one-cycle latency skips the wait state so the beat lands at c+1.
          state_d  = (lat_init == '0) ? S_BEAT : S_LAT;
        end
      end
      S_LAT: begin
        if (!D_req) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - LAT_ONE;
          if (lat_q == LAT_ONE) state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        if (last_beat) begin
          mem_we  = write_q;
          state_d = S_RECOV;
        end else if (!D_req) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are computed from the next state; bursts return the
    // line highest word first so the final beat ends up in the low word.
    rd_idx = cache_d ? {widx_d[ADDR_W-1:2], ~beat_d} : widx_d;
    wait_d = (state_d != S_BEAT);
    out_d  = (!wait_d && !write_d) ? mem_q[rd_idx] : 32'h0;
  end

  always_comb begin
    strb = 4'b0000;
    case (type_q)
      `CACHE_WORD:  strb = 4'b1111;
      `CACHE_HWORD: strb = (boff_q == 2'b00) ? 4'b0011 : 4'b1100;
      `CACHE_BYTE:  strb = 4'b0001 << boff_q;
      default:      strb = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      beat_q  <= 2'd0;
      widx_q  <= '0;
      boff_q  <= 2'd0;
      write_q <= 1'b0;
      data_q  <= 32'h0;
      type_q  <= 3'd0;
      cache_q <= 1'b0;
      wait_q  <= 1'b1;
      out_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      widx_q  <= widx_d;
      boff_q  <= boff_d;
      write_q <= write_d;
      data_q  <= data_d;
      type_q  <= type_d;
      cache_q <= cache_d;
      wait_q  <= wait_d;
      out_q   <= out_d;
    end
  end

  // Array contents survive reset; a write commits only on its beat edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[widx_q][8*b +: 8] <= data_q[8*b +: 8];
      end
    end
  end

  assign D_wait = wait_q;
  assign D_out  = out_q;

endmodule

// File: tb/tb_l1c_mem_responder.sv
// Bench for l1c_mem_responder: two instances (default latencies and RD_LAT=1/WR_LAT=3)
// checked transaction by transaction against a word-array reference model.
`timescale 1ns/1ps

`ifndef CACHE_BYTE
`define CACHE_BYTE  3'b000
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD 3'b001
`endif
`ifndef CACHE_WORD
`define CACHE_WORD  3'b010
`endif

module tb_l1c_mem_responder;

  localparam logic [21:0] UNC_TAG = 22'h040000;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       D_req;
  logic [1:0][31:0] D_addr;
  logic [1:0]       D_write;
  logic [1:0][31:0] D_in;
  logic [1:0][2:0]  D_type;
  logic [1:0][31:0] D_out;
  logic [1:0]       D_wait;

  int          rd_lat_of [2] = '{2, 1};
  int          wr_lat_of [2] = '{1, 3};
  logic [31:0] model_mem [2][1024];
  logic [31:0] exp_q [$];
  logic [31:0] got_beats [4];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  l1c_mem_responder u_dut0 (
    .clk(clk), .rstn(rstn), .D_req(D_req[0]), .D_addr(D_addr[0]), .D_write(D_write[0]),
    .D_in(D_in[0]), .D_type(D_type[0]), .D_out(D_out[0]), .D_wait(D_wait[0])
  );

  l1c_mem_responder #(.RD_LAT(1), .WR_LAT(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .D_req(D_req[1]), .D_addr(D_addr[1]), .D_write(D_write[1]),
    .D_in(D_in[1]), .D_type(D_type[1]), .D_out(D_out[1]), .D_wait(D_wait[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // New word after a write of the given size at the given byte offset.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] t, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (t == `CACHE_WORD) r = d;
    else if (t == `CACHE_HWORD) begin
      if (off == 2'b00) r[15:0] = d[15:0];
      else r[31:16] = d[31:16];
    end else if (t == `CACHE_BYTE) r[8*off +: 8] = d[8*off +: 8];
    return r;
  endfunction

  task automatic scramble(input int u);
    D_addr[u]  = $urandom;
    D_in[u]    = $urandom;
    D_type[u]  = 3'($urandom_range(0, 7));
    D_write[u] = 1'($urandom_range(0, 1));
  endtask

  task automatic xact(input int u, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic [2:0] typ,
                      input int abort_at, input bit hold);
    logic [9:0]  idx;
    bit          unc;
    int          n;
    int          lat_exp;
    int          waited;
    logic [31:0] e;
    idx = addr[11:2];
    unc = (addr[31:10] == UNC_TAG);
    exp_q.delete();
    for (int k = 0; k < 4; k++) got_beats[k] = 32'h0;
    n = (wr || unc) ? 1 : 4;
    lat_exp = wr ? wr_lat_of[u] : rd_lat_of[u];
    if (!wr) begin
      if (unc) exp_q.push_back(model_mem[u][idx]);
      else for (int k = 3; k >= 0; k--) exp_q.push_back(model_mem[u][{idx[9:2], 2'(k)}]);
    end

    @(posedge clk); #1;
    D_req[u] = 1'b1; D_addr[u] = addr; D_write[u] = wr; D_in[u] = data; D_type[u] = typ;
    waited = 0;
    @(negedge clk);
    while (D_wait[u] && waited < 40) begin
      check("wait_out", D_out[u], 32'h0);
      if (waited > 0) scramble(u);
      waited++;
      @(negedge clk);
    end
    check($sformatf("lat_u%0d", u), 32'(waited), 32'(lat_exp));

    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check("beat_wait", {31'h0, D_wait[u]}, 32'h0);
      end
      if (!wr) begin
        e = exp_q.pop_front();
        got_beats[k] = D_out[u];
        check($sformatf("beat%0d_u%0d", k, u), D_out[u], e);
      end
      if (k == abort_at) break;
      scramble(u);
    end

    if (abort_at >= 0 && abort_at < n - 1) begin
      D_req[u] = 1'b0;
      @(negedge clk);
      check("abort_wait", {31'h0, D_wait[u]}, 32'h1);
      check("abort_out", D_out[u], 32'h0);
      return;
    end

    if (wr) model_mem[u][idx] = merge(model_mem[u][idx], data, typ, addr[1:0]);
    @(posedge clk); #1;
    if (!hold) D_req[u] = 1'b0;
    @(negedge clk);
    check("recov_wait", {31'h0, D_wait[u]}, 32'h1);
    check("recov_out", D_out[u], 32'h0);
    if (hold) begin
      @(posedge clk); #1;
      D_req[u] = 1'b0;
      @(negedge clk);
      check("nodup_wait", {31'h0, D_wait[u]}, 32'h1);
    end
  endtask

  task automatic abort_write(input int u, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    D_req[u] = 1'b1; D_addr[u] = addr; D_write[u] = 1'b1; D_in[u] = data;
    D_type[u] = `CACHE_WORD;
    @(posedge clk); #1;
    D_req[u] = 1'b0;
    for (int k = 0; k < wr_lat_of[u] + 1; k++) begin
      @(negedge clk);
      check("wabort_wait", {31'h0, D_wait[u]}, 32'h1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          waited;
    int          u;
    int          op;
    int          ab;
    bit          hold;
    logic [9:0]  idx;
    logic [31:0] a;
    logic [2:0]  t;

    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      D_req[k] = 1'b0; D_addr[k] = 32'h0; D_write[k] = 1'b0; D_in[k] = 32'h0; D_type[k] = 3'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_wait", {31'h0, D_wait[k]}, 32'h1);
      check("reset_out", D_out[k], 32'h0);
    end
    rstn = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) xact(k, 32'(i) << 2, 1'b1, $urandom, `CACHE_WORD, -1, 1'b0);

    // Word write then the enclosing line, highest word first.
    xact(0, 32'h0000_0108, 1'b1, 32'hDEADBEEF, `CACHE_WORD, -1, 1'b0);
    xact(0, 32'h0000_0100, 1'b0, 32'h0, `CACHE_BYTE, -1, 1'b0);
    check("line_beat1", got_beats[1], 32'hDEADBEEF);

    // Sub-word writes read back through the uncacheable window and a burst.
    xact(0, 32'h0000_0200, 1'b1, 32'h11223344, `CACHE_WORD, -1, 1'b0);
    xact(0, 32'h0000_0202, 1'b1, 32'h00AA0000, `CACHE_BYTE, -1, 1'b0);
    xact(0, 32'h1000_0200, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);
    check("byte_rb", got_beats[0], 32'h11AA3344);
    xact(0, 32'h0000_0202, 1'b1, 32'hBBBB0000, `CACHE_HWORD, -1, 1'b0);
    xact(0, 32'h0000_0200, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);
    check("hword_rb", got_beats[3], 32'hBBBB3344);

    xact(0, 32'h1000_0004, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);
    xact(1, 32'h1000_0004, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);

    // Request held high into recovery must not be answered twice.
    xact(0, 32'h0000_0140, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b1);
    xact(0, 32'h0000_0180, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b1);
    xact(1, 32'h0000_0140, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b1);
    xact(1, 32'h1000_0010, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b1);
    xact(1, 32'h0000_0044, 1'b1, 32'h5A5A5A5A, `CACHE_WORD, -1, 1'b1);

    // Aborts: burst after beat 1, and a write dropped while waiting.
    xact(0, 32'h0000_0100, 1'b0, 32'h0, `CACHE_WORD, 1, 1'b0);
    xact(0, 32'h0000_0100, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);
    abort_write(1, 32'h0000_0300, 32'hCAFEF00D);
    xact(1, 32'h1000_0300, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);

    // Asynchronous reset during a burst.
    @(posedge clk); #1;
    D_req[0] = 1'b1; D_addr[0] = 32'h0000_0040; D_write[0] = 1'b0; D_type[0] = `CACHE_WORD;
    waited = 0;
    @(negedge clk);
    while (D_wait[0] && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    check("rst_pre_beat", {31'h0, D_wait[0]}, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("rst_wait", {31'h0, D_wait[0]}, 32'h1);
    check("rst_out", D_out[0], 32'h0);
    D_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    xact(0, 32'h0000_0040, 1'b0, 32'h0, `CACHE_WORD, -1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      u    = $urandom_range(0, 1);
      op   = $urandom_range(0, 2);
      idx  = 10'($urandom_range(0, 255));
      hold = 1'($urandom_range(0, 1));
      t    = 3'($urandom_range(0, 2));
      case (op)
        0: begin
          a  = {20'($urandom), idx, 2'($urandom)};
          ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
          xact(u, a, 1'b0, $urandom, 3'($urandom_range(0, 7)), ab, hold);
        end
        1: begin
          a = {UNC_TAG, idx[7:0], 2'($urandom)};
          xact(u, a, 1'b0, $urandom, t, -1, hold);
        end
        default: begin
          a = {20'($urandom), idx, 2'($urandom)};
          if ($urandom_range(0, 7) == 0) t = 3'($urandom_range(3, 7));
          xact(u, a, 1'b1, $urandom, t, -1, hold);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
